// File: rtl/vga_mem_arbiter.sv
// ---------------------------------------------------------------------------
// vga_mem_arbiter
//
// Purpose:
//   Scans a VGA frame out of a shared single-port framebuffer RAM. In the
//   same RAM, one writer (drawing engine or CPU) can store pixels. The block
//   runs at twice the pixel rate and splits every pixel period into two RAM
//   cycles:
//     phase 0 : display read slot. It is used only while (h,v) is inside the
//               active window. Outside that window it goes to the writer.
//     phase 1 : always a writer slot.
//   The display read always wins. The writer sees wr_ready low in the cycles
//   the display owns.
//
// Optional feature (macro VGA_WR_VBLANK_ONLY_EN):
//   When defined, the writer is granted only on lines outside the active
//   vertical window, so the frame is updated tear-free during vblank.
//   When undefined, the writer gets every cycle the display does not use.
//
// Ports:
//   clk          system clock, 2x pixel clock
//   rst_n        asynchronous active-low reset
//   wr_valid     writer request; payload is held until the transfer
//   wr_ready     writer granted this cycle (combinational, ignores wr_valid)
//   wr_addr      writer address
//   wr_data      writer data
//   mem_addr     RAM address
//   mem_we       RAM write enable
//   mem_wdata    RAM write data
//   mem_rdata    RAM read data, valid 1 clk after the address
//   Hsynq        horizontal sync, active low (registered)
//   Vsynq        vertical sync, active low (registered)
//   blank        1 = active video, 0 = blanking (registered)
//   pixel        pixel value, 0 outside active video (registered)
//   frame_start  one-clk pulse on the first output cycle of pixel (0,0)
// ---------------------------------------------------------------------------
module vga_mem_arbiter #(
  parameter int ADDR_W      = 19,
  parameter int DATA_W      = 8,
  parameter int H_TOTAL     = 800,
  parameter int H_SYNC      = 96,
  parameter int H_ACT_START = 144,
  parameter int H_ACT       = 640,
  parameter int V_TOTAL     = 525,
  parameter int V_SYNC      = 2,
  parameter int V_ACT_START = 35,
  parameter int V_ACT       = 480
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              Hsynq,
  output logic              Vsynq,
  output logic              blank,
  output logic [DATA_W-1:0] pixel,
  output logic              frame_start
);

  localparam int H_W = $clog2(H_TOTAL);
  localparam int V_W = $clog2(V_TOTAL);

  // Counter limits and window edges, sized to the counters so every compare
  // is width-matched. The "last" forms keep the end of the window inside the
  // counter range, even when a window runs to the end of the line or frame.
  localparam logic [H_W-1:0]    H_LAST      = H_W'(H_TOTAL - 1);
  localparam logic [V_W-1:0]    V_LAST      = V_W'(V_TOTAL - 1);
  localparam logic [H_W-1:0]    H_SYNC_END  = H_W'(H_SYNC);
  localparam logic [V_W-1:0]    V_SYNC_END  = V_W'(V_SYNC);
  localparam logic [H_W-1:0]    H_ACT_FIRST = H_W'(H_ACT_START);
  localparam logic [H_W-1:0]    H_ACT_LAST  = H_W'(H_ACT_START + H_ACT - 1);
  localparam logic [V_W-1:0]    V_ACT_FIRST = V_W'(V_ACT_START);
  localparam logic [V_W-1:0]    V_ACT_LAST  = V_W'(V_ACT_START + V_ACT - 1);
  localparam logic [ADDR_W-1:0] LINE_STEP   = ADDR_W'(H_ACT);

  // Timing state
  logic              phase_q, phase_d;
  logic [H_W-1:0]    h_q, h_d;
  logic [V_W-1:0]    v_q, v_d;
  logic [ADDR_W-1:0] line_base_q, line_base_d;

  // Registered DAC-side outputs
  logic              hsynq_q, hsynq_d;
  logic              vsynq_q, vsynq_d;
  logic              blank_q, blank_d;
  logic [DATA_W-1:0] pixel_q, pixel_d;
  logic              frame_start_q, frame_start_d;

  // Decoded position and arbitration
  logic              act_h;
  logic              act_v;
  logic              act;
  logic              display_slot;
  logic              wr_window;
  logic [H_W-1:0]    h_off;
  logic [ADDR_W-1:0] rd_addr;

  // Decode the active window from the current counters. act describes the
  // pixel period in progress. The output registers capture it at the end of
  // that period.
  always_comb begin
    act_h = (h_q >= H_ACT_FIRST) && (h_q <= H_ACT_LAST);
    act_v = (v_q >= V_ACT_FIRST) && (v_q <= V_ACT_LAST);
    act   = act_h && act_v;
    display_slot = !phase_q && act;
  end

  // Read address. line_base steps by one line width per active line, so no
  // multiplier is needed. h_off is meaningful only inside the active window,
  // and that is the only place rd_addr is used.
  always_comb begin
    h_off   = h_q - H_ACT_FIRST;
    rd_addr = line_base_q + ADDR_W'(h_off);
  end

  // Writer grant window. With the vblank-only option, the writer is locked
  // out for whole active lines, including their horizontal blanking.
  always_comb begin
`ifdef VGA_WR_VBLANK_ONLY_EN
    wr_window = !act_v;
`else
    wr_window = 1'b1;
`endif
  end

  // RAM port mux. wr_ready is qualified with rst_n, so an outstanding write
  // is dropped as soon as reset is asserted, not at the next clock edge.
  always_comb begin
    wr_ready  = rst_n && wr_window && !display_slot;
    mem_we    = wr_valid && wr_ready;
    mem_addr  = display_slot ? rd_addr : wr_addr;
    mem_wdata = wr_data;
  end

  // Phase toggles every clock. h/v advance at the end of phase 1, so each
  // (h,v) is held for exactly two clocks: one display slot, then one writer
  // slot.
  always_comb begin
    phase_d = !phase_q;
    h_d     = h_q;
    v_d     = v_q;
    if (phase_q) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + V_W'(1);
      end else begin
        h_d = h_q + H_W'(1);
      end
    end
  end

  // line_base moves to the next row after the last active pixel of every
  // active line. It restarts during line 0, well before the first active
  // line.
  always_comb begin
    line_base_d = line_base_q;
    if (v_q == '0) begin
      line_base_d = '0;
    end else if (phase_q && act_v && (h_q == H_ACT_LAST)) begin
      line_base_d = line_base_q + LINE_STEP;
    end
  end

  // The output registers load at the end of phase 1, when mem_rdata holds
  // the word addressed in phase 0 of the same pixel period. They therefore
  // describe the period that just ended, 2 clk after the counters took it.
  // frame_start loads every clock, so its pulse lasts one clock instead of a
  // whole pixel period.
  always_comb begin
    hsynq_d       = hsynq_q;
    vsynq_d       = vsynq_q;
    blank_d       = blank_q;
    pixel_d       = pixel_q;
    frame_start_d = phase_q && (h_q == '0) && (v_q == '0);
    if (phase_q) begin
      hsynq_d = (h_q >= H_SYNC_END);
      vsynq_d = (v_q >= V_SYNC_END);
      blank_d = act;
      pixel_d = act ? mem_rdata : '0;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q       <= 1'b0;
      h_q           <= '0;
      v_q           <= '0;
      line_base_q   <= '0;
      hsynq_q       <= 1'b1;
      vsynq_q       <= 1'b1;
      blank_q       <= 1'b0;
      pixel_q       <= '0;
      frame_start_q <= 1'b0;
    end else begin
      phase_q       <= phase_d;
      h_q           <= h_d;
      v_q           <= v_d;
      line_base_q   <= line_base_d;
      hsynq_q       <= hsynq_d;
      vsynq_q       <= vsynq_d;
      blank_q       <= blank_d;
      pixel_q       <= pixel_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign Hsynq       = hsynq_q;
  assign Vsynq       = vsynq_q;
  assign blank       = blank_q;
  assign pixel       = pixel_q;
  assign frame_start = frame_start_q;

endmodule

// File: doc/vga_mem_arbiter.md
# vga_mem_arbiter

Scans out a 640x480 VGA frame from a shared single-port framebuffer RAM while letting one writer (drawing engine or CPU) store pixels into the same RAM. The block runs at twice the pixel rate and owns the H/V counters. It generates the registered Hsynq/Vsynq/blank/pixel outputs for the DAC. It also arbitrates every RAM cycle between the display read and the writer. The display read has absolute priority.

## Interface
Parameters:
- ADDR_W, 19, framebuffer address width (must cover H_ACT*V_ACT)
- DATA_W, 8, pixel/RAM word width
- H_TOTAL, 800, pixel periods per line
- H_SYNC, 96, Hsynq low for h < H_SYNC
- H_ACT_START, 144, first active h
- H_ACT, 640, active pixels per line
- V_TOTAL, 525, lines per frame
- V_SYNC, 2, Vsynq low for v < V_SYNC
- V_ACT_START, 35, first active v
- V_ACT, 480, active lines

Ports:
- clk, in, 1, system clock, 2x pixel clock (50 MHz for 25 MHz pixels)
- rst_n, in, 1, asynchronous active-low reset
- wr_valid, in, 1, writer request
- wr_ready, out, 1, writer granted this cycle
- wr_addr, in, ADDR_W, writer address
- wr_data, in, DATA_W, writer data
- mem_addr, out, ADDR_W, RAM address
- mem_we, out, 1, RAM write enable
- mem_wdata, out, DATA_W, RAM write data
- mem_rdata, in, DATA_W, RAM read data, valid 1 clk after address
- Hsynq, out, 1, horizontal sync, active low
- Vsynq, out, 1, vertical sync, active low
- blank, out, 1, 1 = active video (pixel valid), 0 = blanking
- pixel, out, DATA_W, pixel value, 0 whenever blank=0
- frame_start, out, 1, one-clk pulse on first output cycle of pixel (0,0)

## Operation
- `phase` toggles every clk. h (0..H_TOTAL-1) advances on phase=1. At H_TOTAL-1, h wraps to 0 and v increments. v wraps from V_TOTAL-1 to 0.
- `act` = (H_ACT_START <= h < H_ACT_START+H_ACT) && (V_ACT_START <= v < V_ACT_START+V_ACT).
- Display slot = phase=0 && act. In that slot: mem_addr = rd_addr, mem_we = 0.
- rd_addr = line_base + (h - H_ACT_START). No multiplier.
  - line_base clears at v=0.
  - line_base += H_ACT after the last active pixel of each active line.
- Writer slot = every other cycle. wr_ready is combinational, = !display_slot, and does not depend on wr_valid.
- Writer handshake: transfer occurs when wr_valid && wr_ready. That cycle: mem_addr = wr_addr, mem_we = 1, mem_wdata = wr_data. The writer holds its payload until the transfer.
- Non-display cycles with no write: mem_we = 0, mem_addr = wr_addr.
- Outputs are registered and update only on phase=1 edges. They describe the (h,v) of the pixel period just ended:
  - pixel = act ? mem_rdata : 0
  - Hsynq = (h >= H_SYNC)
  - Vsynq = (v >= V_SYNC)
  - blank = act
- Write/read collision on the same address is impossible (distinct cycles). A write lands before any later display read.

## Timing
- Reset values: Hsynq=1, Vsynq=1, blank=0, pixel=0, frame_start=0, wr_ready=0, mem_we=0, phase=0, h=0, v=0, line_base=0.
- rst_n assertion mid-frame forces all reset values immediately. Any write not yet clocked is dropped. After release, scanning restarts at (0,0).
- Output latency: outputs reflect the counter value (h,v) 2 clk after the counters take it.
- Display read: address in phase 0; mem_rdata sampled at the end of phase 1.
- Writer bandwidth:
  - Active region: 1 write per 2 clk.
  - Blanking: 1 write per clk.
- frame_start: high for exactly the first clk in which outputs correspond to (0,0). One pulse per 2*H_TOTAL*V_TOTAL clk.
- Full frame period = 2*800*525 = 840000 clk.

## Configuration
- VGA_WR_VBLANK_ONLY_EN defined:
  - wr_ready = 1 only when v < V_ACT_START or v >= V_ACT_START+V_ACT, and it is not a display slot.
  - Writes during active lines, including horizontal blanking, are stalled. This gives tear-free updates.
- Undefined: writer arbitration as described in Operation.

## Test plan
- Reset release, run 840000 clk:
  - Hsynq low for 192 clk of every 1600.
  - Vsynq low for exactly 2 lines.
  - blank high 1280 clk per active line over 480 lines.
  - frame_start pulses once.
- Preload RAM with addr[7:0]:
  - pixel at output (h=144,v=35) = 0x00.
  - pixel at (h=145,v=35) = 0x01.
  - First pixel of line v=36 shows address 640 (0x80).
- wr_valid held high through an active line: wr_ready alternates 0/1 and mem_we never coincides with a display slot. In blanking, wr_ready=1 every clk.
- Write 0xAB to address 0 during vblank: next frame, pixel at (144,35) = 0xAB.
- Assert rst_n low at h=300,v=200 for 3 clk: outputs immediately at reset values. After release, frame_start occurs 2 clk after counters restart at (0,0).
- With VGA_WR_VBLANK_ONLY_EN: wr_valid high at v=100 gives wr_ready=0 until v=515, then the write completes.
